// File: rtl/xpt_sequencer.sv
// Opcode register (ITABLE) and execution-step counter (XPT) sequencer for the decoder tree.
// Define XPT_SEQ_OVERFLOW_GUARD_EN to trap step overruns in a sticky FAULT state; otherwise XPT wraps.
//
// state | meaning
// FETCH | waiting for opcode byte, CM1 high
// EXEC  | stepping XPT, decoders enabled unless mem_wait
// FAULT | XPT ran past XPT_MAX without a reset strobe; left only by RESET
module xpt_sequencer #(
    parameter int unsigned XPT_MAX = 15
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       mem_wait,
    input  logic [7:0] opcode,
    input  logic       opcode_valid,
    input  logic       PR_Reset_XPT,
    input  logic       P2_Set_CM1,
    input  logic       P2_Reset_ITABLE,
    output logic [3:0] XPT,
    output logic [3:0] notXPT,
    output logic [7:0] ITABLE,
    output logic [7:0] notITABLE,
    output logic       decode_enable,
    output logic       CM1,
    output logic       xpt_overflow
);

    localparam logic [3:0] XPT_LAST = XPT_MAX[3:0];

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] xpt_inc;

    assign xpt_inc       = XPT + 4'd1;
    assign decode_enable = (state == EXEC) && !mem_wait;

`ifndef XPT_SEQ_OVERFLOW_GUARD_EN
    assign xpt_overflow = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= FETCH;
            XPT       <= 4'h0;
            notXPT    <= 4'hF;
            ITABLE    <= 8'h00;
            notITABLE <= 8'hFF;
            CM1       <= 1'b1;
`ifdef XPT_SEQ_OVERFLOW_GUARD_EN
            xpt_overflow <= 1'b0;
`endif
        end else begin
            case (state)
                FETCH: begin
                    if (opcode_valid && !mem_wait) begin
                        ITABLE    <= opcode;
                        notITABLE <= ~opcode;
                        XPT       <= 4'h0;
                        notXPT    <= 4'hF;
                        CM1       <= 1'b0;
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    // A stalled cycle leaves every register untouched so no step repeats.
                    if (!mem_wait) begin
                        if (P2_Reset_ITABLE) begin
                            ITABLE    <= 8'h00;
                            notITABLE <= 8'hFF;
                        end
                        if (P2_Set_CM1) begin
                            XPT    <= 4'h0;
                            notXPT <= 4'hF;
                            CM1    <= 1'b1;
                            state  <= FETCH;
                        end else if (PR_Reset_XPT) begin
                            XPT    <= 4'h0;
                            notXPT <= 4'hF;
                        end else if (XPT == XPT_LAST) begin
`ifdef XPT_SEQ_OVERFLOW_GUARD_EN
                            state        <= FAULT;
                            xpt_overflow <= 1'b1;
`else
                            XPT    <= 4'h0;
                            notXPT <= 4'hF;
`endif
                        end else begin
                            XPT    <= xpt_inc;
                            notXPT <= ~xpt_inc;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
